// File: rtl/dsp_share_arbiter.sv
// Round-robin sharing of one pipelined (D+-B)*A+-C DSP slice between two ports.
// Optional grant/stall counters: define DSP_SHARE_ARBITER_STATS_EN.
module dsp_share_arbiter #(
  parameter int DSP_LATENCY     = 4,
  parameter int C_SKEW          = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [17:0] req_a0,
  input  logic [17:0] req_a1,
  input  logic [17:0] req_b0,
  input  logic [17:0] req_b1,
  input  logic [17:0] req_d0,
  input  logic [17:0] req_d1,
  input  logic [47:0] req_c0,
  input  logic [47:0] req_c1,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [17:0] dsp_d,
  output logic [47:0] dsp_c,
  output logic        dsp_rst_n,
  input  logic [47:0] dsp_p,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [47:0] rsp_p
`ifdef DSP_SHARE_ARBITER_STATS_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [2:0] MAXO = 3'(MAX_OUTSTANDING);

  logic [1:0][2:0]              outst_q, outst_d;
  logic                         last_q, last_d;
  logic [DSP_LATENCY-1:0]       tv_q, tv_d;
  logic [DSP_LATENCY-1:0]       tid_q, tid_d;
  logic [C_SKEW-1:0][47:0]      c_q, c_d;
  logic [1:0]                   retire;
  logic [1:0]                   elig;
  logic [1:0]                   grant;
  logic                         gid;
  logic [47:0]                  c_in;

  assign rsp_valid = tv_q[DSP_LATENCY-1];
  assign rsp_id    = tid_q[DSP_LATENCY-1];
  assign rsp_p     = dsp_p;
  assign dsp_c     = c_q[C_SKEW-1];
  assign dsp_rst_n = ~rst;
  assign req_ready = grant;

  always_comb begin
    retire    = '0;
    elig      = '0;
    grant     = '0;
    gid       = 1'b0;
    dsp_a     = '0;
    dsp_b     = '0;
    dsp_d     = '0;
    c_in      = '0;
    retire[0] = rsp_valid & ~rsp_id;
    retire[1] = rsp_valid & rsp_id;
    // a slot retiring this cycle frees its credit immediately
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] &
                ((outst_q[i] - {2'b0, retire[i]}) < MAXO);
    end
    if (!rst) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    gid = grant[1];
    unique case (1'b1)
      grant[0]: begin
        dsp_a = req_a0;
        dsp_b = req_b0;
        dsp_d = req_d0;
        c_in  = req_c0;
      end
      grant[1]: begin
        dsp_a = req_a1;
        dsp_b = req_b1;
        dsp_d = req_d1;
        c_in  = req_c1;
      end
      default: ;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    last_d  = last_q;
    tv_d    = '0;
    tid_d   = '0;
    c_d     = '0;
    for (int i = 0; i < 2; i++) begin
      outst_d[i] = outst_q[i] + {2'b0, grant[i]}
                 - {2'b0, retire[i]};
    end
    if (|grant) last_d = gid;
    tv_d[0]  = |grant;
    tid_d[0] = gid;
    for (int k = 1; k < DSP_LATENCY; k++) begin
      tv_d[k]  = tv_q[k-1];
      tid_d[k] = tid_q[k-1];
    end
    c_d[0] = c_in;
    for (int k = 1; k < C_SKEW; k++) begin
      c_d[k] = c_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
      last_q  <= 1'b1;
      tv_q    <= '0;
      tid_q   <= '0;
      c_q     <= '0;
    end else begin
      outst_q <= outst_d;
      last_q  <= last_d;
      tv_q    <= tv_d;
      tid_q   <= tid_d;
      c_q     <= c_d;
    end
  end

`ifdef DSP_SHARE_ARBITER_STATS_EN
  logic [31:0] gc0_q, gc0_d;
  logic [31:0] gc1_q, gc1_d;
  logic [31:0] sc_q, sc_d;

  assign grant_cnt0 = gc0_q;
  assign grant_cnt1 = gc1_q;
  assign stall_cnt  = sc_q;

  always_comb begin
    gc0_d = gc0_q + {31'b0, grant[0]};
    gc1_d = gc1_q + {31'b0, grant[1]};
    sc_d  = sc_q + {31'b0, (|req_valid) & ~(|grant)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gc0_q <= '0;
      gc1_q <= '0;
      sc_q  <= '0;
    end else begin
      gc0_q <= gc0_d;
      gc1_q <= gc1_d;
      sc_q  <= sc_d;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Scoreboard bench for dsp_share_arbiter with a behavioural DSP slice.
// Responses are predicted from the arbitration rules and (D+B)*A+C.
module tb_dsp_share_arbiter;

  localparam int LAT  = 4;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [1:0]  req_ready;
  logic [17:0] op_a [2];
  logic [17:0] op_b [2];
  logic [17:0] op_d [2];
  logic [47:0] op_c [2];
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p, rsp_p;
  logic        dsp_rst_n, rsp_valid, rsp_id;
`ifdef DSP_SHARE_ARBITER_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  dsp_share_arbiter #(
    .DSP_LATENCY(LAT),
    .C_SKEW(2),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(vld), .req_ready(req_ready),
    .req_a0(op_a[0]), .req_a1(op_a[1]),
    .req_b0(op_b[0]), .req_b1(op_b[1]),
    .req_d0(op_d[0]), .req_d1(op_d[1]),
    .req_c0(op_c[0]), .req_c1(op_c[1]),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d),
    .dsp_c(dsp_c), .dsp_rst_n(dsp_rst_n), .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p)
`ifdef DSP_SHARE_ARBITER_STATS_EN
    ,
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // behavioural slice in ADD mode, C joins two cycles after A/B/D
  logic [17:0] s1a, s1b, s1d;
  logic [47:0] s2, s3, s4;
  always @(posedge clk) begin
    if (!dsp_rst_n) begin
      s1a <= '0; s1b <= '0; s1d <= '0;
      s2 <= '0; s3 <= '0; s4 <= '0;
    end else begin
      s1a <= dsp_a; s1b <= dsp_b; s1d <= dsp_d;
      s2  <= ({30'b0, s1d} + {30'b0, s1b}) * {30'b0, s1a};
      s3  <= s2 + dsp_c;
      s4  <= s3;
    end
  end
  assign dsp_p = s4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic [47:0] p;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   q0[$];
  int   q1[$];
  logic last;
  int   gcnt0, gcnt1, scnt;
  int   rv_seen;

  function automatic logic [47:0] pmod(input logic [17:0] a, b, d,
                                       input logic [47:0] c);
    return ({30'b0, d} + {30'b0, b}) * {30'b0, a} + c;
  endfunction

  task automatic step();
    logic [1:0] el, g;
    logic       id;
    logic [63:0] eabd;
    exp_t       e;
    @(negedge clk);
    if (rst) begin
      check("rst_ready", {62'b0, req_ready}, 64'd0);
      check("rst_dsp_rst_n", {63'b0, dsp_rst_n}, 64'd0);
      sb.delete(); q0.delete(); q1.delete();
      last = 1'b1;
      gcnt0 = 0; gcnt1 = 0; scnt = 0;
    end else begin
      while (q0.size() > 0 && q0[0] <= cyc) void'(q0.pop_front());
      while (q1.size() > 0 && q1[0] <= cyc) void'(q1.pop_front());
      el[0] = vld[0] && (q0.size() < MAXO);
      el[1] = vld[1] && (q1.size() < MAXO);
      if (el == 2'b11) g = last ? 2'b01 : 2'b10;
      else g = el;
      check("grant", {62'b0, req_ready}, {62'b0, g});
      id   = g[1];
      eabd = '0;
      if (|g) eabd = {10'b0, op_a[id], op_b[id], op_d[id]};
      check("dsp_abd", {10'b0, dsp_a, dsp_b, dsp_d}, eabd);
      if (|g) begin
        e.id  = id;
        e.p   = pmod(op_a[id], op_b[id], op_d[id], op_c[id]);
        e.due = cyc + LAT;
        sb.push_back(e);
        if (id) q1.push_back(cyc + LAT);
        else q0.push_back(cyc + LAT);
        last = id;
        if (id) gcnt1++;
        else gcnt0++;
      end else if (|vld) scnt++;
      if (rsp_valid) rv_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
          check("rsp_p", {16'b0, rsp_p}, {16'b0, e.p});
          check("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_rsp", 64'd0, 64'd1);
      end
      check("outst0_bound", {61'b0, dut.outst_q[0]} <= MAXO, 64'd1);
      check("outst1_bound", {61'b0, dut.outst_q[1]} <= MAXO, 64'd1);
    end
  end

  task automatic set_op(input int p, input logic [17:0] a, b, d,
                        input logic [47:0] c);
    op_a[p] = a; op_b[p] = b; op_d[p] = d; op_c[p] = c;
  endtask

  task automatic rand_ops();
    for (int p = 0; p < 2; p++) begin
      set_op(p, 18'($urandom), 18'($urandom), 18'($urandom),
             {16'($urandom), 32'($urandom)});
    end
  endtask

  task automatic idle(input int n);
    vld = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    vld = 2'b00;
    last = 1'b1;
    gcnt0 = 0; gcnt1 = 0; scnt = 0; rv_seen = 0;
    set_op(0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_id", {63'b0, rsp_id}, 64'd0);
    check("rst_dsp_c", {16'b0, dsp_c}, 64'd0);
    rst = 1'b0;
    idle(2);

    // single op: (5+2)*3+10 = 31
    set_op(0, 18'd3, 18'd2, 18'd5, 48'd10);
    vld = 2'b01;
    step();
    idle(6);

    // contention: both ports hold valid for 6 cycles
    rand_ops();
    vld = 2'b11;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      step();
    end
    idle(6);

    // credit cap: port 1 holds valid continuously
    vld = 2'b10;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      step();
    end
    idle(6);

    // C skew: back-to-back port-0 ops, results 101 and 201
    vld = 2'b01;
    set_op(0, 18'd1, 18'd0, 18'd1, 48'd100);
    step();
    set_op(0, 18'd1, 18'd0, 18'd1, 48'd200);
    step();
    idle(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      vld = 2'($urandom);
      step();
    end
    idle(6);

    // reset mid-flight
    vld = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rv_seen = 0;
    idle(6);
    check("post_rst_no_rsp", 64'(rv_seen), 64'd0);
    check("post_rst_outst0", {61'b0, dut.outst_q[0]}, 64'd0);
    check("post_rst_outst1", {61'b0, dut.outst_q[1]}, 64'd0);
    rand_ops();
    vld = 2'b11;
    #1;
    check("post_rst_tie", {62'b0, req_ready}, 64'd1);
    step();
    for (int i = 0; i < 60; i++) begin
      rand_ops();
      vld = 2'($urandom);
      step();
    end
    idle(8);
    check("sb_drained", 64'(sb.size()), 64'd0);
`ifdef DSP_SHARE_ARBITER_STATS_EN
    check("grant_cnt0", {32'b0, grant_cnt0}, 64'(gcnt0));
    check("grant_cnt1", {32'b0, grant_cnt1}, 64'(gcnt1));
    check("stall_cnt", {32'b0, stall_cnt}, 64'(scnt));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
